// File: rtl/servo_motor_pkg.sv
// Shared types and constants for the servo/motor command sequencer.
// Holds the ramp FSM state encoding, the command byte layout, the default
// failsafe targets and the servo target clamp helper.
package servo_motor_pkg;

    // Command byte layout: bit 7 picks the channel, bits 6:0 carry the target.
    localparam int unsigned CH_SEL_BIT = 32'd7;
    localparam int unsigned DUTY_W     = 32'd7;

    // Default failsafe targets: servo centred, motor stopped.
    localparam logic [6:0] SERVO_SAFE_DEF = 7'd64;
    localparam logic [6:0] MOTOR_SAFE_DEF = 7'd0;

    // Ramp sequencer: wait for a tick, step the motor, then step the servo.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_M = 2'd1,
        STEP_S = 2'd2
    } seq_state_t;

    // Clamp a requested servo target into the accepted window [lo, hi].
    function automatic logic [6:0] clamp_servo(
        input logic [6:0] req,
        input logic [6:0] lo,
        input logic [6:0] hi
    );
        logic [6:0] res;
        if (req < lo) begin
            res = lo;
        end else if (req > hi) begin
            res = hi;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_motor_sequencer_slew_step.sv
// slew_step: one bounded ramp step from the current duty toward a target.
// Purely combinational; the sequencer time-shares a single instance between
// the motor and servo channels.
module slew_step
    import servo_motor_pkg::*;
(
    input  logic [DUTY_W-1:0] current,
    input  logic [DUTY_W-1:0] target,
    input  logic [DUTY_W-1:0] step,
    output logic [DUTY_W-1:0] next
);

    logic signed [7:0] diff_s;
    logic        [7:0] mag_s;

    // Snap to target when within one step, otherwise move one step toward it.
    // Moving by a full step only happens when the target is more than a step
    // away, so the 7-bit sum/difference can never wrap outside 0..127.
    always_comb begin
        diff_s = $signed({1'b0, target}) - $signed({1'b0, current});
        if (diff_s[7]) begin
            mag_s = 8'd0 - diff_s;
        end else begin
            mag_s = diff_s;
        end
        if (mag_s <= {1'b0, step}) begin
            next = target;
        end else if (diff_s[7]) begin
            next = current - step;
        end else begin
            next = current + step;
        end
    end

endmodule

// File: rtl/servo_motor_sequencer.sv
// servo_motor_sequencer: decodes command bytes into per-channel targets and
// slews the applied motor/servo duties toward them, one bounded step per
// channel per ramp tick, pulsing a load strobe whenever a duty changes.
// Optional feature macro: SERVO_MOTOR_WDT_EN builds in the command watchdog
// that forces both channels to their safe targets when commands stop.
module servo_motor_sequencer
    import servo_motor_pkg::*;
#(
    parameter logic [16:0] RAMP_DIV   = 17'd5000,
    parameter logic [6:0]  STEP       = 7'd2,
    parameter logic [6:0]  SERVO_MIN  = 7'd10,
    parameter logic [6:0]  SERVO_MAX  = 7'd118,
    parameter logic [6:0]  SERVO_SAFE = SERVO_SAFE_DEF,
    parameter logic [6:0]  MOTOR_SAFE = MOTOR_SAFE_DEF,
    parameter logic [31:0] WDT_CYCLES = 32'd5_000_000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [7:0] control_val,
    input  logic       data_ready,
    output logic [6:0] motor_duty,
    output logic [6:0] servo_duty,
    output logic       motor_load,
    output logic       servo_load,
    output logic       failsafe,
    output logic       busy
);

    logic [16:0]       tick_cnt_r;
    logic              tick_s;
    seq_state_t        state_r;
    seq_state_t        state_nxt_s;
    logic [6:0]        motor_tgt_r;
    logic [6:0]        servo_tgt_r;
    logic [6:0]        motor_duty_r;
    logic [6:0]        servo_duty_r;
    logic              motor_load_r;
    logic              servo_load_r;
    logic              failsafe_r;
    logic [6:0]        slew_cur_s;
    logic [6:0]        slew_tgt_s;
    logic [6:0]        slew_next_s;
    logic              cmd_servo_s;
    logic [6:0]        cmd_val_s;
    logic [6:0]        cmd_servo_tgt_s;
    logic              wdt_hit_s;

    assign tick_s          = (tick_cnt_r == (RAMP_DIV - 17'd1));
    assign cmd_servo_s     = control_val[CH_SEL_BIT];
    assign cmd_val_s       = control_val[DUTY_W-1:0];
    assign cmd_servo_tgt_s = clamp_servo(cmd_val_s, SERVO_MIN, SERVO_MAX);

    // Ramp tick prescaler: free-running 0..RAMP_DIV-1, tick at terminal count.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tick_cnt_r <= 17'd0;
        end else if (tick_s) begin
            tick_cnt_r <= 17'd0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 17'd1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and steering of the shared slew stepper.
    always_comb begin
        state_nxt_s = state_r;
        slew_cur_s  = motor_duty_r;
        slew_tgt_s  = motor_tgt_r;
        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    state_nxt_s = STEP_M;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STEP_M: begin
                state_nxt_s = STEP_S;
            end
            STEP_S: begin
                state_nxt_s = IDLE;
                slew_cur_s  = servo_duty_r;
                slew_tgt_s  = servo_tgt_r;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    slew_step u_slew_step (
        .current (slew_cur_s),
        .target  (slew_tgt_s),
        .step    (STEP),
        .next    (slew_next_s)
    );

    // Applied duties and their load strobes; a strobe marks the first cycle a
    // changed duty is visible, so an unchanged step produces no strobe.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            motor_duty_r <= MOTOR_SAFE;
            servo_duty_r <= SERVO_SAFE;
            motor_load_r <= 1'b0;
            servo_load_r <= 1'b0;
        end else begin
            if (state_r == STEP_M) begin
                motor_duty_r <= slew_next_s;
                motor_load_r <= (slew_next_s != motor_duty_r);
            end else begin
                motor_load_r <= 1'b0;
            end
            if (state_r == STEP_S) begin
                servo_duty_r <= slew_next_s;
                servo_load_r <= (slew_next_s != servo_duty_r);
            end else begin
                servo_load_r <= 1'b0;
            end
        end
    end

`ifdef SERVO_MOTOR_WDT_EN
    logic [31:0] idle_cnt_r;

    // Command idle counter: cleared by every command, saturates at timeout.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            idle_cnt_r <= 32'd0;
        end else if (data_ready) begin
            idle_cnt_r <= 32'd0;
        end else if (idle_cnt_r != (WDT_CYCLES - 32'd1)) begin
            idle_cnt_r <= idle_cnt_r + 32'd1;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    assign wdt_hit_s = (idle_cnt_r == (WDT_CYCLES - 32'd1));
`else
    // Without the watchdog the timeout never fires; the timeout parameter is
    // still part of the interface so both builds share one parameter list.
    assign wdt_hit_s = (WDT_CYCLES == 32'd0) && 1'b0;
`endif

    // Channel targets and failsafe flag. A command only retargets its own
    // channel and wins over a simultaneous watchdog timeout.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            motor_tgt_r <= MOTOR_SAFE;
            servo_tgt_r <= SERVO_SAFE;
            failsafe_r  <= 1'b0;
        end else if (data_ready) begin
            failsafe_r <= 1'b0;
            if (cmd_servo_s) begin
                servo_tgt_r <= cmd_servo_tgt_s;
            end else begin
                motor_tgt_r <= cmd_val_s;
            end
        end else if (wdt_hit_s) begin
            motor_tgt_r <= MOTOR_SAFE;
            servo_tgt_r <= SERVO_SAFE;
            failsafe_r  <= 1'b1;
        end else begin
            failsafe_r <= failsafe_r;
        end
    end

    assign motor_duty = motor_duty_r;
    assign servo_duty = servo_duty_r;
    assign motor_load = motor_load_r;
    assign servo_load = servo_load_r;
    assign failsafe   = failsafe_r;
    assign busy       = (motor_duty_r != motor_tgt_r) | (servo_duty_r != servo_tgt_r);

endmodule

// File: tb/tb_servo_motor_sequencer.sv
// Directed self-checking bench for servo_motor_sequencer (RAMP_DIV = 8,
// STEP = 2). Outputs are sampled on the falling clock edge.
// With SERVO_MOTOR_WDT_EN defined the watchdog sequence is exercised too.
module tb_servo_motor_sequencer;

    localparam logic [16:0] RDIV = 17'd8;
    localparam int          RD   = 8;
    localparam int          WAIT_LIMIT = 3 * RD + 4;

    logic       clk;
    logic       clr_n;
    logic [7:0] control_val;
    logic       data_ready;
    logic [6:0] motor_duty;
    logic [6:0] servo_duty;
    logic       motor_load;
    logic       servo_load;
    logic       failsafe;
    logic       busy;

    int total_cnt;
    int bad_cnt;
    bit b2b_seen;
    bit prev_m;
    bit prev_s;

    servo_motor_sequencer #(
        .RAMP_DIV   (RDIV),
        .STEP       (7'd2),
        .SERVO_MIN  (7'd10),
        .SERVO_MAX  (7'd118),
        .SERVO_SAFE (7'd64),
        .MOTOR_SAFE (7'd0),
        .WDT_CYCLES (32'd2000)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .control_val (control_val),
        .data_ready  (data_ready),
        .motor_duty  (motor_duty),
        .servo_duty  (servo_duty),
        .motor_load  (motor_load),
        .servo_load  (servo_load),
        .failsafe    (failsafe),
        .busy        (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watch for a strobe held high on two consecutive cycles.
    always @(negedge clk) begin
        if ((motor_load && prev_m) || (servo_load && prev_s)) b2b_seen = 1'b1;
        prev_m = motor_load;
        prev_s = servo_load;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One-cycle command strobe; returns on the falling edge after capture.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        control_val = b;
        data_ready  = 1'b1;
        @(negedge clk);
        data_ready  = 1'b0;
    endtask

    // Wait (bounded) for the chosen channel's load strobe.
    task automatic wait_strobe(input bit is_servo, output int cycles);
        bit seen;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < WAIT_LIMIT) begin
            @(negedge clk);
            cycles++;
            seen = is_servo ? servo_load : motor_load;
        end
        if (!seen) check_eq(is_servo ? "servo_strobe_timeout" : "motor_strobe_timeout", 32'd0, 32'd1);
    endtask

    // Run n cycles and count any strobes.
    task automatic idle_watch(input int n, output int strobes);
        strobes = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (motor_load || servo_load) strobes++;
        end
    endtask

    initial begin
        int cyc;
        int nstb;
        logic [6:0] exp_seq [5];

        total_cnt   = 0;
        bad_cnt     = 0;
        b2b_seen    = 1'b0;
        clr_n       = 1'b0;
        control_val = 8'h00;
        data_ready  = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_motor_duty", 32'(motor_duty), 32'd0);
        check_eq("rst_servo_duty", 32'(servo_duty), 32'd64);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_failsafe", 32'(failsafe), 32'd0);
        clr_n = 1'b1;
        idle_watch(3 * RD, nstb);
        check_eq("idle_strobes", 32'(nstb), 32'd0);
        check_eq("idle_motor_duty", 32'(motor_duty), 32'd0);
        check_eq("idle_servo_duty", 32'(servo_duty), 32'd64);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Motor target 10: steps 2,4,6,8,10 one tick apart.
        send(8'h0A);
        check_eq("m10_busy_on", 32'(busy), 32'd1);
        check_eq("m10_no_direct", 32'(motor_duty), 32'd0);
        wait_strobe(1'b0, cyc);
        check_eq("m10_latency_ok", 32'(cyc <= RD + 2), 32'd1);
        check_eq("m10_step1", 32'(motor_duty), 32'd2);
        for (int i = 2; i <= 5; i++) begin
            wait_strobe(1'b0, cyc);
            check_eq("m10_gap", 32'(cyc), 32'(RD));
            check_eq("m10_step", 32'(motor_duty), 32'(2 * i));
        end
        @(negedge clk);
        check_eq("m10_busy_off", 32'(busy), 32'd0);

        // Servo request 127 clamps to 118: 27 ticks from 64.
        send(8'hFF);
        for (int i = 1; i <= 27; i++) begin
            wait_strobe(1'b1, cyc);
            check_eq("s118_step", 32'(servo_duty), 32'(64 + 2 * i));
        end
        @(negedge clk);
        check_eq("s118_busy_off", 32'(busy), 32'd0);
        idle_watch(2 * RD, nstb);
        check_eq("s118_settled", 32'(nstb), 32'd0);

        // Servo request 0 clamps to 10.
        send(8'h80);
        check_eq("s10_busy_on", 32'(busy), 32'd1);
        wait_strobe(1'b1, cyc);
        check_eq("s10_first", 32'(servo_duty), 32'd116);
        for (int i = 2; i <= 54; i++) wait_strobe(1'b1, cyc);
        check_eq("s10_final", 32'(servo_duty), 32'd10);
        idle_watch(2 * RD, nstb);
        check_eq("s10_settled", 32'(nstb), 32'd0);
        check_eq("s10_busy_off", 32'(busy), 32'd0);

        // Command landing on a motor step edge: step uses old target 20.
        send(8'h14);
        wait_strobe(1'b0, cyc);
        check_eq("coll_pre", 32'(motor_duty), 32'd12);
        repeat (RD - 1) @(negedge clk);
        control_val = 8'h05;
        data_ready  = 1'b1;
        @(negedge clk);
        data_ready  = 1'b0;
        check_eq("coll_old_tgt", 32'(motor_duty), 32'd14);
        check_eq("coll_load", 32'(motor_load), 32'd1);
        exp_seq = '{7'd12, 7'd10, 7'd8, 7'd6, 7'd5};
        for (int i = 0; i < 5; i++) begin
            wait_strobe(1'b0, cyc);
            check_eq("coll_new_tgt", 32'(motor_duty), 32'(exp_seq[i]));
        end
        @(negedge clk);
        check_eq("coll_busy_off", 32'(busy), 32'd0);

`ifdef SERVO_MOTOR_WDT_EN
        // Watchdog: motor to 40, then silence until failsafe.
        send(8'h28);
        repeat (1990) @(negedge clk);
        check_eq("wdt_motor40", 32'(motor_duty), 32'd40);
        check_eq("wdt_not_yet", 32'(failsafe), 32'd0);
        cyc = 0;
        while (!failsafe && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("wdt_failsafe", 32'(failsafe), 32'd1);
        for (int i = 0; i < 20; i++) wait_strobe(1'b0, cyc);
        check_eq("wdt_motor_safe", 32'(motor_duty), 32'd0);
        send(8'h05);
        check_eq("wdt_cleared", 32'(failsafe), 32'd0);
        for (int i = 0; i < 3; i++) wait_strobe(1'b0, cyc);
        check_eq("wdt_motor5", 32'(motor_duty), 32'd5);
`endif

        // Asynchronous reset in the middle of a servo ramp.
        send(8'hFF);
        wait_strobe(1'b1, cyc);
        repeat (3) @(negedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        check_eq("arst_motor", 32'(motor_duty), 32'd0);
        check_eq("arst_servo", 32'(servo_duty), 32'd64);
        check_eq("arst_sload", 32'(servo_load), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        idle_watch(3 * RD, nstb);
        check_eq("arst_no_strobes", 32'(nstb), 32'd0);
        check_eq("arst_busy_after", 32'(busy), 32'd0);
        check_eq("arst_failsafe", 32'(failsafe), 32'd0);
        check_eq("no_back_to_back", 32'(b2b_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
